// File: rtl/bin_to_bcd_display_feeder.sv
// Sequential binary to 7-segment digit-code converter using a one-bit-per-clock
// double-dabble engine; results are held stable until the next conversion completes.
module bin_to_bcd_display_feeder #(
    parameter int BIN_WIDTH     = 14,
    parameter int NUM_DIGITS    = 4,
    parameter int LEADING_BLANK = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Start,
    input  logic [BIN_WIDTH-1:0]    i_Bin,
    output logic                    o_Busy,
    output logic                    o_Done,
    output logic                    o_Overflow,
    output logic [5*NUM_DIGITS-1:0] o_Digits
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int CMP_W = (BIN_WIDTH > 27) ? BIN_WIDTH : 27;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(pow10(NUM_DIGITS) - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state_reg;
    logic [BIN_WIDTH-1:0]    bin_reg;
    logic [BCD_W-1:0]        bcd_reg;
    logic [BCD_W-1:0]        bcd_adj;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    ovf_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    overflow_reg;
    logic [5*NUM_DIGITS-1:0] digits_reg;
    logic [5*NUM_DIGITS-1:0] digits_next;
    logic                    is_over;

    assign is_over = CMP_W'(i_Bin) > MAX_VAL;

    // Add-3 correction applied to every nibble before each shift.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        end
    endgenerate

    // Zeros above the first nonzero digit are blanked; the ones digit always shows.
    always_comb begin
        logic seen;
        digits_next = '0;
        seen        = 1'b0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            if (LEADING_BLANK != 0 && d != 0 && !seen && bcd_reg[4*d +: 4] == 4'd0) begin
                digits_next[5*d +: 5] = 5'h10;
            end else begin
                digits_next[5*d +: 5] = {1'b0, bcd_reg[4*d +: 4]};
            end
            if (bcd_reg[4*d +: 4] != 4'd0) begin
                seen = 1'b1;
            end
        end
    end

    // An overflowing value still passes through SHIFT with a zero count, so the
    // overflow result arrives one cycle after acceptance like a degenerate conversion.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_reg    <= IDLE;
            bin_reg      <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            digits_reg   <= {NUM_DIGITS{5'h10}};
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_Start) begin
                        bin_reg   <= i_Bin;
                        bcd_reg   <= '0;
                        ovf_reg   <= is_over;
                        cnt_reg   <= is_over ? '0 : CNT_W'(BIN_WIDTH);
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_reg != '0) begin
                        bcd_reg <= {bcd_adj[BCD_W-2:0], bin_reg[BIN_WIDTH-1]};
                        bin_reg <= bin_reg << 1;
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                        if (ovf_reg) begin
                            overflow_reg <= 1'b1;
                            digits_reg   <= {NUM_DIGITS{5'h1F}};
                        end else begin
                            overflow_reg <= 1'b0;
                            digits_reg   <= digits_next;
                        end
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_Busy     = busy_reg;
    assign o_Done     = done_reg;
    assign o_Overflow = overflow_reg;
    assign o_Digits   = digits_reg;

endmodule

// File: tb/tb_bin_to_bcd_display_feeder.sv
// Directed bench for bin_to_bcd_display_feeder: two instances (leading blank on/off)
// share one stimulus stream; results are checked against hand values and a decimal model.
module tb_bin_to_bcd_display_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        busy, done, ovf;
    logic [19:0] digits;
    logic        busy0, done0, ovf0;
    logic [19:0] digits0;

    int vectors = 0;
    int errs = 0;

    always #5 clk = ~clk;

    bin_to_bcd_display_feeder #(.BIN_WIDTH(14), .NUM_DIGITS(4), .LEADING_BLANK(1)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Bin(bin),
        .o_Busy(busy), .o_Done(done), .o_Overflow(ovf), .o_Digits(digits)
    );

    bin_to_bcd_display_feeder #(.BIN_WIDTH(14), .NUM_DIGITS(4), .LEADING_BLANK(0)) dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Bin(bin),
        .o_Busy(busy0), .o_Done(done0), .o_Overflow(ovf0), .o_Digits(digits0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference built with division, independent of the shift-and-add engine.
    function automatic logic [19:0] model(input int v, input bit lb);
        logic [19:0] r;
        int          dg[4];
        bit          seen;
        r    = '0;
        seen = 1'b0;
        if (v > 9999) return 20'hFFFFF;
        dg[0] = v % 10;
        dg[1] = (v / 10) % 10;
        dg[2] = (v / 100) % 10;
        dg[3] = (v / 1000) % 10;
        for (int i = 3; i >= 0; i--) begin
            if (lb && !seen && i != 0 && dg[i] == 0) r[5*i +: 5] = 5'h10;
            else                                     r[5*i +: 5] = 5'(dg[i]);
            if (dg[i] != 0) seen = 1'b1;
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where o_Done is seen (or timeout).
    task automatic convert(input int v, output int lat, output int busy_cnt);
        start = 1'b1;
        bin   = 14'(v);
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        $display("convert %0d: latency %0d digits %05h ovf %0b", v, lat, digits, ovf);
    endtask

    initial begin
        int lat, bc, dcnt, n;
        logic [19:0] got;
        int vals[$];

        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(1'b0));
        chk("reset_done", 64'(done), 64'(1'b0));
        chk("reset_ovf", 64'(ovf), 64'(1'b0));
        chk("reset_digits", 64'(digits), 64'(20'h84210));
        rst = 1'b0;
        @(negedge clk);

        convert(1234, lat, bc);
        chk("lat_1234", 64'(lat), 64'(16));
        chk("busy_1234", 64'(bc), 64'(15));
        chk("busy_at_done", 64'(busy), 64'(1'b1));
        chk("dig_1234", 64'(digits), 64'(20'h08864));
        chk("ovf_1234", 64'(ovf), 64'(1'b0));
        @(negedge clk);
        chk("done_pulse_1", 64'(done), 64'(1'b0));
        chk("busy_after", 64'(busy), 64'(1'b0));

        convert(7, lat, bc);
        chk("dig_7_lb", 64'(digits), 64'(20'h84207));
        chk("dig_7_nolb", 64'(digits0), 64'(20'h00007));
        @(negedge clk);
        convert(0, lat, bc);
        chk("dig_0_lb", 64'(digits), 64'(20'h84200));
        chk("dig_0_nolb", 64'(digits0), 64'(20'h00000));
        @(negedge clk);

        convert(9999, lat, bc);
        chk("dig_9999", 64'(digits), 64'(20'h4A529));
        chk("ovf_9999", 64'(ovf), 64'(1'b0));
        @(negedge clk);
        convert(10000, lat, bc);
        chk("lat_10000", 64'(lat), 64'(2));
        chk("dig_10000", 64'(digits), 64'(20'hFFFFF));
        chk("ovf_10000", 64'(ovf), 64'(1'b1));
        @(negedge clk);

        // Second request during SHIFT must be ignored.
        start = 1'b1;
        bin   = 14'd42;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        bin   = 14'd99;
        @(negedge clk);
        start = 1'b0;
        bin   = '0;
        dcnt  = 0;
        got   = '0;
        repeat (30) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                if (dcnt == 1) got = digits;
            end
        end
        $display("ignore test: done pulses %0d digits %05h", dcnt, got);
        chk("ignore_done_cnt", 64'(dcnt), 64'(1));
        chk("ignore_digits", 64'(got), 64'(20'h84082));
        chk("ignore_idle", 64'(busy), 64'(1'b0));

        // Asynchronous reset in the middle of a conversion.
        start = 1'b1;
        bin   = 14'd1234;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("async reset mid-shift: busy %0b done %0b ovf %0b digits %05h", busy, done, ovf, digits);
        chk("arst_busy", 64'(busy), 64'(1'b0));
        chk("arst_done", 64'(done), 64'(1'b0));
        chk("arst_ovf", 64'(ovf), 64'(1'b0));
        chk("arst_digits", 64'(digits), 64'(20'h84210));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Continuous start with stepping input values.
        for (int v = 0; v < 16384; v += 123) vals.push_back(v);
        vals.push_back(1);
        vals.push_back(10);
        vals.push_back(100);
        vals.push_back(1000);
        vals.push_back(9998);
        vals.push_back(9999);
        vals.push_back(10000);
        vals.push_back(10001);
        vals.push_back(16383);
        bin   = 14'(vals[0]);
        start = 1'b1;
        for (int i = 0; i < vals.size(); i++) begin
            n = 0;
            @(negedge clk);
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            $display("stream %0d: digits %05h/%05h ovf %0b", vals[i], digits, digits0, ovf);
            chk("stream_done", 64'(done), 64'(1'b1));
            chk("stream_lb", 64'(digits), 64'(model(vals[i], 1'b1)));
            chk("stream_nolb", 64'(digits0), 64'(model(vals[i], 1'b0)));
            chk("stream_ovf", 64'(ovf), 64'(vals[i] > 9999));
            if (i + 1 < vals.size()) bin = 14'(vals[i+1]);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
